// File: rtl/tpm_buf_arbiter.sv
// TPM command/response buffer arbiter.
// Shares one single-port 512x32 buffer RAM between the host data provider
// (byte port) and the CPU Wishbone window. Everything runs on the Wishbone
// clock. exec_i decides which side owns the buffer, and a non-owner access
// is terminated with an error. The block also tracks the host write
// high-water mark, which the CPU reads as the command length.
module tpm_buf_arbiter #(
  parameter int          ADDR_WIDTH         = 11,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    exec_i,
  input  logic                    dp_req_i,
  input  logic                    dp_we_i,
  input  logic [ADDR_WIDTH-1:0]   dp_addr_i,
  input  logic [7:0]              dp_wdata_i,
  output logic [7:0]              dp_rdata_o,
  output logic                    dp_ack_o,
  output logic                    dp_err_o,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-3:0]   ram_a_o,
  output logic [31:0]             ram_wd_o,
  output logic [3:0]              ram_wen_o,
  input  logic [31:0]             ram_rd_i,
  output logic                    owner_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH:0]     hwm_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  wb_req, owner_req, other_req;
  logic                  grant, reject;
  logic                  cur_wb, cur_we, cur_err;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   addr_plus1;
  logic [3:0]            dp_lane_en;
  logic                  exec_q, exec_fall, dp_write_done;
  logic                  in_resp;

  assign wb_req     = wb_cyc_i & wb_stb_i;
  assign in_resp    = (state == RESP);
  assign busy_o     = (state != IDLE);
  assign addr_plus1 = {1'b0, cur_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign exec_fall  = exec_q & ~exec_i;
  // Only a host write can be in ACCESS with cur_wb low and cur_we high.
  // Errors never reach ACCESS.
  assign dp_write_done = (state == ACCESS) & ~cur_wb & cur_we;

  assign wb_ack_o = in_resp &  cur_wb & ~cur_err;
  assign wb_err_o = in_resp &  cur_wb &  cur_err;
  assign dp_ack_o = in_resp & ~cur_wb & ~cur_err;
  assign dp_err_o = in_resp & ~cur_wb &  cur_err;

  // State register. An asynchronous reset drops any in-flight access without an ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Arbitration and sequencing. The owner wins; a lone non-owner goes straight to an error response.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    reject     = 1'b0;
    owner_req  = exec_i ? wb_req   : dp_req_i;
    other_req  = exec_i ? dp_req_i : wb_req;
    case (state)
      IDLE: begin
        if (owner_req) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end else if (other_req) begin
          reject     = 1'b1;
          state_next = RESP;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Host byte write enable: the byte lane is selected by the low address bits (little-endian).
  always_comb begin
    dp_lane_en = 4'b0000;
    case (dp_addr_i[1:0])
      2'b00:   dp_lane_en = 4'b0001;
      2'b01:   dp_lane_en = 4'b0010;
      2'b10:   dp_lane_en = 4'b0100;
      default: dp_lane_en = 4'b1000;
    endcase
  end

  // Latch the granted request and drive the RAM port. Write enables last only for the ACCESS cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_wb    <= 1'b0;
      cur_we    <= 1'b0;
      cur_err   <= 1'b0;
      cur_addr  <= '0;
      owner_o   <= 1'b0;
      ram_a_o   <= '0;
      ram_wd_o  <= '0;
      ram_wen_o <= '0;
    end else if (grant) begin
      cur_wb  <= exec_i;
      cur_err <= 1'b0;
      owner_o <= exec_i;
      if (exec_i) begin
        cur_we    <= wb_we_i;
        cur_addr  <= wb_adr_i;
        ram_a_o   <= wb_adr_i[ADDR_WIDTH-1:2];
        ram_wd_o  <= wb_dat_i;
        ram_wen_o <= wb_we_i ? wb_sel_i : 4'b0000;
      end else begin
        cur_we    <= dp_we_i;
        cur_addr  <= dp_addr_i;
        ram_a_o   <= dp_addr_i[ADDR_WIDTH-1:2];
        ram_wd_o  <= {4{dp_wdata_i}};
        ram_wen_o <= dp_we_i ? dp_lane_en : 4'b0000;
      end
    end else if (reject) begin
      cur_wb    <= ~exec_i;
      cur_err   <= 1'b1;
      cur_we    <= exec_i ? dp_we_i : wb_we_i;
      ram_wen_o <= '0;
    end else begin
      ram_wen_o <= '0;
    end
  end

  // High-water mark. A host write completing on the clear cycle wins over the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exec_q <= 1'b0;
      hwm_o  <= '0;
    end else begin
      exec_q <= exec_i;
      if (dp_write_done) begin
        if (exec_fall || (addr_plus1 > hwm_o)) hwm_o <= addr_plus1;
      end else if (exec_fall) begin
        hwm_o <= '0;
      end
    end
  end

  // Wishbone read data is presented only while a read is being acked.
  always_comb begin
    wb_dat_o = DEFAULT_READ_VALUE;
    if (wb_ack_o && !cur_we) wb_dat_o = ram_rd_i;
  end

  // Host read byte. The lane is taken from the latched address; a rejected host access returns 0xFF.
  always_comb begin
    dp_rdata_o = 8'h00;
    if (dp_err_o) begin
      dp_rdata_o = 8'hFF;
    end else if (dp_ack_o && !cur_we) begin
      case (cur_addr[1:0])
        2'b00:   dp_rdata_o = ram_rd_i[7:0];
        2'b01:   dp_rdata_o = ram_rd_i[15:8];
        2'b10:   dp_rdata_o = ram_rd_i[23:16];
        default: dp_rdata_o = ram_rd_i[31:24];
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// Testbench for tpm_buf_arbiter. Directed accesses push their expected
// termination into a queue. A monitor pops and compares every ack/err the
// DUT presents. The RAM is a simple synchronous 512x32 array.
module tb_tpm_buf_arbiter;

  localparam int          AW  = 11;
  localparam logic [31:0] DEF = 32'hBADFABAC;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          exec_i = 1'b0;
  logic          dp_req_i = 1'b0, dp_we_i = 1'b0;
  logic [AW-1:0] dp_addr_i = '0;
  logic [7:0]    dp_wdata_i = '0;
  logic [7:0]    dp_rdata_o;
  logic          dp_ack_o, dp_err_o;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [AW-1:0] wb_adr_i = '0;
  logic [3:0]    wb_sel_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [AW-3:0] ram_a_o;
  logic [31:0]   ram_wd_o;
  logic [3:0]    ram_wen_o;
  logic [31:0]   ram_rd_i;
  logic          owner_o, busy_o;
  logic [AW:0]   hwm_o;

  tpm_buf_arbiter #(.ADDR_WIDTH(AW), .DEFAULT_READ_VALUE(DEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .exec_i(exec_i),
    .dp_req_i(dp_req_i), .dp_we_i(dp_we_i), .dp_addr_i(dp_addr_i),
    .dp_wdata_i(dp_wdata_i), .dp_rdata_o(dp_rdata_o),
    .dp_ack_o(dp_ack_o), .dp_err_o(dp_err_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_a_o(ram_a_o), .ram_wd_o(ram_wd_o), .ram_wen_o(ram_wen_o),
    .ram_rd_i(ram_rd_i), .owner_o(owner_o), .busy_o(busy_o), .hwm_o(hwm_o)
  );

  always #5 clk_i = ~clk_i;

  // Buffer RAM: byte-masked write, registered read
  logic [31:0] mem [512];
  logic [31:0] wmask;
  assign wmask = {{8{ram_wen_o[3]}}, {8{ram_wen_o[2]}}, {8{ram_wen_o[1]}}, {8{ram_wen_o[0]}}};
  initial for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  always @(posedge clk_i) begin
    if (ram_wen_o != 4'b0000) mem[ram_a_o] <= (mem[ram_a_o] & ~wmask) | (ram_wd_o & wmask);
    ram_rd_i <= mem[ram_a_o];
  end

  // kind: 0 wb ack, 1 wb err, 2 dp ack, 3 dp err
  typedef struct {
    logic [1:0]  kind;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  resp_t         exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            no_write = 1'b0;
  logic [AW-3:0] last_a = '0;
  logic [31:0]   last_wd = '0;
  logic [3:0]    last_wen = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectResp(input logic [1:0] kind, input logic chk, input logic [31:0] data);
    resp_t e;
    e.kind = kind;
    e.chk  = chk;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drives one request from a negedge, waits for its termination and checks
  // the latency (the drive cycle counts as cycle 1). It then drops the request
  // and lets the DUT return to IDLE.
  task automatic applyStimulus(input string name, input bit use_wb, input bit we,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int exp_lat);
    int cyc;
    bit seen;
    if (use_wb) begin
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = addr; wb_dat_i = wdata; wb_sel_i = sel;
    end else begin
      dp_req_i = 1'b1; dp_we_i = we; dp_addr_i = addr; dp_wdata_i = wdata[7:0];
    end
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
      seen = use_wb ? (wb_ack_o | wb_err_o) : (dp_ack_o | dp_err_o);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: no termination within %0d cycles, expected %0d", name, cyc, exp_lat);
    end else if (exp_lat != 0) begin
      checkOutput({name, " latency"}, cyc, exp_lat);
    end
    if (use_wb) begin
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    end else begin
      dp_req_i = 1'b0; dp_we_i = 1'b0;
    end
    @(negedge clk_i);
  endtask

  // Monitor: compare every termination against the scoreboard and check the per-cycle invariants
  always @(negedge clk_i) begin : monitor
    int         n;
    logic [1:0] ak;
    resp_t      e;
    n  = int'(wb_ack_o) + int'(wb_err_o) + int'(dp_ack_o) + int'(dp_err_o);
    ak = wb_ack_o ? 2'd0 : wb_err_o ? 2'd1 : dp_ack_o ? 2'd2 : 2'd3;
    if (n != 0) begin
      checkOutput("single termination", n, 1);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected response: got kind %0d, expected none", ak);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp kind", {30'b0, ak}, {30'b0, e.kind});
        if (e.chk) checkOutput("resp data", (ak < 2) ? wb_dat_o : {24'b0, dp_rdata_o}, e.data);
      end
    end
    if (!wb_ack_o) checkOutput("wb_dat idle value", wb_dat_o, DEF);
    if (ram_wen_o != 4'b0000) begin
      checkOutput("ram write only while busy", {31'b0, busy_o}, 32'd1);
      last_a   = ram_a_o;
      last_wd  = ram_wd_o;
      last_wen = ram_wen_o;
    end
    if (no_write) checkOutput("no ram write", {28'b0, ram_wen_o}, 32'd0);
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset wb_dat_o", wb_dat_o, DEF);
    checkOutput("reset busy_o", {31'b0, busy_o}, 0);
    checkOutput("reset ram_a_o", {23'b0, ram_a_o}, 0);
    checkOutput("reset ram_wen_o", {28'b0, ram_wen_o}, 0);
    checkOutput("reset hwm_o", {20'b0, hwm_o}, 0);
    checkOutput("reset dp_rdata_o", {24'b0, dp_rdata_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Host owns the buffer: byte write of 0xA5 to 0x006
    exec_i = 1'b0;
    expectResp(2'd2, 1'b0, 32'h0);
    applyStimulus("dp wr 006", 1'b0, 1'b1, 11'h006, 32'hA5, 4'h0, 3);
    checkOutput("dp wr ram_a", {23'b0, last_a}, 32'h001);
    checkOutput("dp wr ram_wen", {28'b0, last_wen}, 32'h4);
    checkOutput("dp wr ram_wd", last_wd, 32'hA5A5A5A5);
    checkOutput("hwm after 006", {20'b0, hwm_o}, 32'd7);

    // CPU owns: read word 0x004, then a write with no byte enables, then a read back
    exec_i = 1'b1;
    expectResp(2'd0, 1'b1, 32'h00A50000);
    applyStimulus("wb rd 004", 1'b1, 1'b0, 11'h004, 32'h0, 4'hF, 3);
    checkOutput("owner after wb grant", {31'b0, owner_o}, 32'd1);
    no_write = 1'b1;
    expectResp(2'd0, 1'b1, DEF);
    applyStimulus("wb wr sel0", 1'b1, 1'b1, 11'h004, 32'hFFFFFFFF, 4'h0, 3);
    no_write = 1'b0;
    expectResp(2'd0, 1'b1, 32'h00A50000);
    applyStimulus("wb rd 004 again", 1'b1, 1'b0, 11'h004, 32'h0, 4'hF, 3);

    // Non-owner accesses error out without touching the RAM
    no_write = 1'b1;
    expectResp(2'd3, 1'b1, 32'hFF);
    applyStimulus("dp rd nonowner", 1'b0, 1'b0, 11'h006, 32'h0, 4'h0, 2);
    exec_i = 1'b0;
    expectResp(2'd1, 1'b1, DEF);
    applyStimulus("wb wr nonowner", 1'b1, 1'b1, 11'h008, 32'h12345678, 4'hF, 2);
    no_write = 1'b0;
    checkOutput("hwm cleared by exec fall", {20'b0, hwm_o}, 32'd0);

    // Simultaneous requests: the WB owner is served first, then the host request errors
    exec_i = 1'b1;
    @(negedge clk_i);
    expectResp(2'd0, 1'b1, 32'h00A50000);
    expectResp(2'd3, 1'b1, 32'hFF);
    fork
      applyStimulus("both wb", 1'b1, 1'b0, 11'h004, 32'h0, 4'hF, 3);
      applyStimulus("both dp", 1'b0, 1'b0, 11'h004, 32'h0, 4'h0, 5);
    join

    // exec_i drops during the WB ACCESS cycle; the write still completes
    expectResp(2'd0, 1'b1, DEF);
    fork
      applyStimulus("wb wr exec flip", 1'b1, 1'b1, 11'h00C, 32'hCAFEF00D, 4'hF, 3);
      begin
        @(negedge clk_i);
        exec_i = 1'b0;
      end
    join
    checkOutput("flip ram_a", {23'b0, last_a}, 32'h003);
    checkOutput("flip ram_wen", {28'b0, last_wen}, 32'hF);
    checkOutput("flip ram_wd", last_wd, 32'hCAFEF00D);

    // High-water mark at the top of the buffer
    expectResp(2'd2, 1'b0, 32'h0);
    applyStimulus("dp wr 7FF", 1'b0, 1'b1, 11'h7FF, 32'h3C, 4'h0, 3);
    checkOutput("hwm after 7FF", {20'b0, hwm_o}, 32'h800);
    checkOutput("7FF ram_a", {23'b0, last_a}, 32'h1FF);
    checkOutput("7FF ram_wen", {28'b0, last_wen}, 32'h8);
    expectResp(2'd2, 1'b0, 32'h0);
    applyStimulus("dp wr 010", 1'b0, 1'b1, 11'h010, 32'h5A, 4'h0, 3);
    checkOutput("hwm after 010", {20'b0, hwm_o}, 32'h800);
    checkOutput("010 ram_wen", {28'b0, last_wen}, 32'h1);
    expectResp(2'd2, 1'b1, 32'h3C);
    applyStimulus("dp rd 7FF", 1'b0, 1'b0, 11'h7FF, 32'h0, 4'h0, 3);
    exec_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("hwm kept on exec rise", {20'b0, hwm_o}, 32'h800);
    exec_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("hwm cleared", {20'b0, hwm_o}, 32'd0);

    // Reset pulse during ACCESS: no ack, and the held request is served after release
    exec_i = 1'b1;
    @(negedge clk_i);
    expectResp(2'd0, 1'b1, 32'h3C000000);
    fork
      applyStimulus("wb rd across reset", 1'b1, 1'b0, 11'h7FC, 32'h0, 4'hF, 5);
      begin
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("mid reset busy_o", {31'b0, busy_o}, 0);
        checkOutput("mid reset owner_o", {31'b0, owner_o}, 0);
        checkOutput("mid reset ram_a_o", {23'b0, ram_a_o}, 0);
        checkOutput("mid reset ram_wd_o", ram_wd_o, 0);
        checkOutput("mid reset wb_ack_o", {31'b0, wb_ack_o}, 0);
        checkOutput("mid reset wb_dat_o", wb_dat_o, DEF);
        @(negedge clk_i);
        rst_i = 1'b0;
      end
    join
    checkOutput("owner after reset regrant", {31'b0, owner_o}, 32'd1);

    repeat (3) @(negedge clk_i);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
